delay_change_sequencer: RTL and testbench

Control block for the variable delay buffer. It owns the buffer's delay_samples input and a wet-path gain that goes to the downstream delay mixer multiplier. When a new delay target arrives, it fades the wet path out, switches the read offset while the path is silent, holds for a pipeline flush and fades back in, so the read pointer never jumps audibly. It sits between the control/register interface and the delay buffer/mixer, and runs on the sample strobe of the audio clock domain.

---
 rtl/delay_change_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_delay_change_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/delay_change_sequencer.sv
// delay_change_sequencer
// Sequences delay changes for the variable delay buffer. A new target fades the
// wet path out, switches the read offset while the path is silent, holds for a
// pipeline flush and fades back in, so the read pointer never jumps audibly.
// Counters advance only on sample_valid.
//
// Optional feature macro: DELAY_GLIDE_EN. When defined, small retargets
// (0 < |delta| <= GLIDE_MAX) step delay_samples by one per sample at full gain.
//
// Ports:
//   clk            system/audio clock
//   reset_n        asynchronous active-low reset
//   sample_valid   one-cycle sample strobe (shared with the delay buffer)
//   target_valid   one-cycle pulse, loads target_delay into pending
//   target_delay   requested delay in samples
//   delay_samples  registered delay offset to the delay buffer
//   wet_gain       registered wet-path gain (all ones = unity)
//   busy           registered, high in any state other than RUN
//   change_done    registered one-cycle pulse when a change completes
module delay_change_sequencer #(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned GAIN_WIDTH    = 16,
  parameter int unsigned FADE_LEN_LOG2 = 8,
  parameter int unsigned HOLD_SAMPLES  = 4,
  parameter int unsigned GLIDE_MAX     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_valid,
  input  logic                  target_valid,
  input  logic [ADDR_WIDTH-1:0] target_delay,
  output logic [ADDR_WIDTH-1:0] delay_samples,
  output logic [GAIN_WIDTH-1:0] wet_gain,
  output logic                  busy,
  output logic                  change_done
);

  localparam int unsigned CW    = FADE_LEN_LOG2 + 1;
  localparam int unsigned HW    = $clog2(HOLD_SAMPLES + 1);
  localparam int unsigned SHIFT = GAIN_WIDTH - FADE_LEN_LOG2;
  localparam logic [CW-1:0] C_FULL    = CW'(1) << FADE_LEN_LOG2;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_SAMPLES);

`ifdef DELAY_GLIDE_EN
  typedef enum logic [2:0] {
    S_RUN, S_FADE_OUT, S_SWITCH, S_HOLD, S_FADE_IN, S_GLIDE
  } state_e;
`else
  typedef enum logic [2:0] {
    S_RUN, S_FADE_OUT, S_SWITCH, S_HOLD, S_FADE_IN
  } state_e;
`endif

  state_e                state_q, state_d;
  logic [CW-1:0]         c_q, c_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] delay_q, delay_d;
  logic [ADDR_WIDTH-1:0] pend_q, pend_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [GAIN_WIDTH-1:0] gain_q, gain_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  differs_c;

`ifdef DELAY_GLIDE_EN
  logic [ADDR_WIDTH-1:0] glide_tgt_q, glide_tgt_d;
  logic [ADDR_WIDTH-1:0] mag_c;
  logic [ADDR_WIDTH-1:0] step_c;

  // Unwrapped distance between pending and current delay
  assign mag_c  = (pend_q > delay_q) ? (pend_q - delay_q) : (delay_q - pend_q);
  assign step_c = (delay_q < glide_tgt_q) ? (delay_q + ADDR_WIDTH'(1))
                                          : (delay_q - ADDR_WIDTH'(1));
`else
  logic unused_glide;
  assign unused_glide = ^32'(GLIDE_MAX);
`endif

  assign differs_c = (pend_q != delay_q);

  // Next-state, counters and registered outputs
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    hold_d      = hold_q;
    delay_d     = delay_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    done_d      = 1'b0;
`ifdef DELAY_GLIDE_EN
    glide_tgt_d = glide_tgt_q;
`endif

    case (state_q)
      S_RUN: begin
        if (pend_flag_q) begin
          if (!differs_c) begin
            pend_flag_d = 1'b0;
          end else begin
`ifdef DELAY_GLIDE_EN
            if (mag_c <= ADDR_WIDTH'(GLIDE_MAX)) begin
              state_d     = S_GLIDE;
              pend_flag_d = 1'b0;
              glide_tgt_d = pend_q;
            end else begin
              state_d = S_FADE_OUT;
            end
`else
            state_d = S_FADE_OUT;
`endif
          end
        end
      end
      S_FADE_OUT: begin
        // c can already be 0 when redirected from the very start of FADE_IN
        if (c_q == '0) begin
          state_d = S_SWITCH;
        end else if (sample_valid) begin
          c_d = c_q - CW'(1);
          if (c_q == CW'(1)) state_d = S_SWITCH;
        end
      end
      S_SWITCH: begin
        delay_d     = pend_q;
        pend_flag_d = 1'b0;
        hold_d      = HOLD_INIT;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (sample_valid) begin
          hold_d = hold_q - HW'(1);
          if (hold_q <= HW'(1)) state_d = S_FADE_IN;
        end
      end
      S_FADE_IN: begin
        // A fresh retarget reverses the fade from the current gain
        if (pend_flag_q && differs_c) begin
          state_d = S_FADE_OUT;
        end else if (sample_valid) begin
          c_d = c_q + CW'(1);
          if (c_q == C_FULL - CW'(1)) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end
        end
      end
`ifdef DELAY_GLIDE_EN
      S_GLIDE: begin
        if (sample_valid) begin
          delay_d = step_c;
          if (step_c == glide_tgt_q) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_RUN;
    endcase

    // A new target always wins over a same-cycle clear
    if (target_valid) begin
      pend_d      = target_delay;
      pend_flag_d = 1'b1;
    end

    gain_d = (c_d == C_FULL) ? '1 : (GAIN_WIDTH'(c_d) << SHIFT);
    busy_d = (state_d != S_RUN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RUN;
      c_q         <= C_FULL;
      hold_q      <= '0;
      delay_q     <= '0;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      gain_q      <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DELAY_GLIDE_EN
      glide_tgt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      hold_q      <= hold_d;
      delay_q     <= delay_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      gain_q      <= gain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DELAY_GLIDE_EN
      glide_tgt_q <= glide_tgt_d;
`endif
    end
  end

  assign delay_samples = delay_q;
  assign wet_gain      = gain_q;
  assign busy          = busy_q;
  assign change_done   = done_q;

endmodule

// File: tb/tb_delay_change_sequencer.sv
// Directed bench for delay_change_sequencer: FADE_LEN_LOG2=2, HOLD_SAMPLES=2,
// sample_valid once every 4 clocks. Each vector row is one sample period.
module tb_delay_change_sequencer;

  logic        clk;
  logic        reset_n;
  logic        sample_valid;
  logic        target_valid;
  logic [15:0] target_delay;
  logic [15:0] delay_samples;
  logic [15:0] wet_gain;
  logic        busy;
  logic        change_done;

  delay_change_sequencer #(
    .ADDR_WIDTH   (16),
    .GAIN_WIDTH   (16),
    .FADE_LEN_LOG2(2),
    .HOLD_SAMPLES (2),
    .GLIDE_MAX    (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .target_valid (target_valid),
    .target_delay (target_delay),
    .delay_samples(delay_samples),
    .wet_gain     (wet_gain),
    .busy         (busy),
    .change_done  (change_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tv;
    logic [15:0] td;
    logic [15:0] gain;
    logic [15:0] dly;
    logic        busy;
    int          done;
  } vec_t;

  vec_t vq[$];
  int   n_cmp;
  int   n_fail;
  int   row_done;
  bit   seen200;

  task automatic add(input logic tv, input logic [15:0] td, input logic [15:0] g,
                     input logic [15:0] d, input logic b, input int dn);
    vec_t v;
    v.tv = tv; v.td = td; v.gain = g; v.dly = d; v.busy = b; v.done = dn;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; inputs applied after the previous edge, outputs read 1ns after this one
  task automatic tick(input logic tv, input logic [15:0] td, input logic sv);
    target_valid = tv;
    target_delay = td;
    sample_valid = sv;
    @(posedge clk);
    #1;
    target_valid = 1'b0;
    sample_valid = 1'b0;
    if (change_done) row_done++;
    if (delay_samples == 16'd200) seen200 = 1'b1;
  endtask

  // One sample period: optional target on clk 0, sample strobe on clk 2
  task automatic run_row(input string tag, input logic tv, input logic [15:0] td,
                         input logic [15:0] eg, input logic [15:0] ed,
                         input logic eb, input int edone);
    row_done = 0;
    tick(tv, td, 1'b0);
    tick(1'b0, 16'd0, 1'b0);
    tick(1'b0, 16'd0, 1'b1);
    tick(1'b0, 16'd0, 1'b0);
    check({tag, " gain"}, int'(wet_gain), int'(eg));
    check({tag, " delay"}, int'(delay_samples), int'(ed));
    check({tag, " busy"}, int'(busy), int'(eb));
    check({tag, " done"}, row_done, edone);
  endtask

`ifdef DELAY_GLIDE_EN
  // Full fade change from old_d to new_d, target issued on the first row
  task automatic fade_change(input string tag, input logic [15:0] old_d,
                             input logic [15:0] new_d);
    logic [15:0] fg [10];
    fg = '{16'hC000, 16'h8000, 16'h4000, 16'h0000, 16'h0000,
           16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
    for (int i = 0; i < 10; i++) begin
      run_row($sformatf("%s%0d", tag, i), (i == 0), new_d, fg[i],
              (i < 3) ? old_d : new_d, (i < 9), (i == 9) ? 1 : 0);
    end
  endtask
`endif

  initial begin
    logic [15:0] cur;
    n_cmp = 0; n_fail = 0; row_done = 0; seen200 = 1'b0;
    reset_n = 1'b0; sample_valid = 1'b0; target_valid = 1'b0; target_delay = '0;

    // Reset values
    #12;
    check("rst gain", int'(wet_gain), 16'hFFFF);
    check("rst delay", int'(delay_samples), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(change_done), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Basic change 0 -> 100
    add(1, 100, 16'hC000,   0, 1, 0);
    add(0,   0, 16'h8000,   0, 1, 0);
    add(0,   0, 16'h4000,   0, 1, 0);
    add(0,   0, 16'h0000, 100, 1, 0);
    add(0,   0, 16'h0000, 100, 1, 0);
    add(0,   0, 16'h0000, 100, 1, 0);
    add(0,   0, 16'h4000, 100, 1, 0);
    add(0,   0, 16'h8000, 100, 1, 0);
    add(0,   0, 16'hC000, 100, 1, 0);
    add(0,   0, 16'hFFFF, 100, 0, 1);
    // Target equal to current: nothing happens
    add(1, 100, 16'hFFFF, 100, 0, 0);
    add(0,   0, 16'hFFFF, 100, 0, 0);
    // 200 then 300 during FADE_OUT: newest wins
    add(1, 200, 16'hC000, 100, 1, 0);
    add(1, 300, 16'h8000, 100, 1, 0);
    add(0,   0, 16'h4000, 100, 1, 0);
    add(0,   0, 16'h0000, 300, 1, 0);
    add(0,   0, 16'h0000, 300, 1, 0);
    add(0,   0, 16'h0000, 300, 1, 0);
    add(0,   0, 16'h4000, 300, 1, 0);
    add(0,   0, 16'h8000, 300, 1, 0);
    add(0,   0, 16'hC000, 300, 1, 0);
    add(0,   0, 16'hFFFF, 300, 0, 1);
    // Change to 400, retarget to 50 in FADE_IN at gain 0x8000
    add(1, 400, 16'hC000, 300, 1, 0);
    add(0,   0, 16'h8000, 300, 1, 0);
    add(0,   0, 16'h4000, 300, 1, 0);
    add(0,   0, 16'h0000, 400, 1, 0);
    add(0,   0, 16'h0000, 400, 1, 0);
    add(0,   0, 16'h0000, 400, 1, 0);
    add(0,   0, 16'h4000, 400, 1, 0);
    add(0,   0, 16'h8000, 400, 1, 0);
    add(1,  50, 16'h4000, 400, 1, 0);
    add(0,   0, 16'h0000,  50, 1, 0);
    add(0,   0, 16'h0000,  50, 1, 0);
    add(0,   0, 16'h0000,  50, 1, 0);
    add(0,   0, 16'h4000,  50, 1, 0);
    add(0,   0, 16'h8000,  50, 1, 0);
    add(0,   0, 16'hC000,  50, 1, 0);
    add(0,   0, 16'hFFFF,  50, 0, 1);

    foreach (vq[i]) begin
      run_row($sformatf("v%0d", i), vq[i].tv, vq[i].td, vq[i].gain,
              vq[i].dly, vq[i].busy, vq[i].done);
    end
    check("never200", int'(seen200), 0);
    cur = 16'd50;

`ifdef DELAY_GLIDE_EN
    // Glide 50 -> 60 at full gain, then a large change takes the fade path
    for (int k = 1; k <= 10; k++) begin
      run_row($sformatf("g%0d", k), (k == 1), 16'd60, 16'hFFFF,
              16'(50 + k), (k < 10), (k == 10) ? 1 : 0);
    end
    fade_change("gf", 16'd60, 16'd150);
    cur = 16'd150;
`endif

    // Asynchronous reset in the middle of FADE_OUT
    run_row("pre_rst", 1'b1, 16'd500, 16'hC000, cur, 1'b1, 0);
    reset_n = 1'b0;
    #2;
    check("arst gain", int'(wet_gain), 16'hFFFF);
    check("arst delay", int'(delay_samples), 0);
    check("arst busy", int'(busy), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_row($sformatf("idle%0d", k), 1'b0, 16'd0, 16'hFFFF, 16'd0, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
